// File: rtl/hub75_stream_writer_pkg.sv
// Shared types for the HUB75 stream writer: FSM state encoding and the
// address-width helper used to size the geometry counters.
package hub75_stream_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WAIT,
    ST_COMMIT
  } wr_state_t;

  // A geometry of 1 still needs a 1-bit address port.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_stream_writer.sv
// Packs a valid/ready raster pixel stream into per-row line-buffer writes and
// commits each filled row with swap/store once the write-in stage is idle.
module hub75_stream_writer
  import hub75_stream_writer_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int N_CHANS     = 3,
  parameter int N_PLANES    = 8,
  parameter int LOG_N_BANKS = addr_bits(N_BANKS),
  parameter int LOG_N_ROWS  = addr_bits(N_ROWS),
  parameter int LOG_N_COLS  = addr_bits(N_COLS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CHANS*N_PLANES-1:0]   in_data,
  input  logic                          in_sof,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [LOG_N_BANKS-1:0]        wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]         wr_row_addr,
  output logic                          wr_row_store,
  input  logic                          wr_row_rdy,
  output logic                          wr_row_swap,
  output logic [N_CHANS*N_PLANES-1:0]   wr_data,
  output logic [LOG_N_COLS-1:0]         wr_col_addr,
  output logic                          wr_en,
  output logic                          frame_done,
  output logic                          sof_err
);

  localparam logic [LOG_N_COLS-1:0]  COL_LAST  = LOG_N_COLS'(N_COLS - 1);
  localparam logic [LOG_N_ROWS-1:0]  ROW_LAST  = LOG_N_ROWS'(N_ROWS - 1);
  localparam logic [LOG_N_BANKS-1:0] BANK_LAST = LOG_N_BANKS'(N_BANKS - 1);

  wr_state_t state, state_nxt;

  logic [LOG_N_COLS-1:0]  col,  col_nxt,  eff_col;
  logic [LOG_N_ROWS-1:0]  row,  row_nxt,  eff_row;
  logic [LOG_N_BANKS-1:0] bank, bank_nxt, eff_bank;

  logic accept;
  logic at_origin;
  logic resync;

  assign in_ready  = (state == ST_FILL);
  assign accept    = in_valid & in_ready;
  assign at_origin = (col == '0) && (row == '0) && (bank == '0);
  assign resync    = accept & in_sof & ~at_origin;

  // A misplaced start-of-frame pixel is treated as if the counters were
  // already at the frame origin, so the same increment path handles both.
  assign eff_col  = resync ? '0 : col;
  assign eff_row  = resync ? '0 : row;
  assign eff_bank = resync ? '0 : bank;

  assign wr_en        = accept;
  assign wr_data      = in_data;
  assign wr_col_addr  = eff_col;
  assign wr_row_addr  = eff_row;
  assign wr_bank_addr = eff_bank;
  assign sof_err      = resync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
      bank  <= '0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      bank  <= bank_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    row_nxt      = row;
    bank_nxt     = bank;
    wr_row_store = 1'b0;
    wr_row_swap  = 1'b0;
    frame_done   = 1'b0;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_FILL;
      end

      ST_FILL: begin
        if (accept) begin
          row_nxt  = eff_row;
          bank_nxt = eff_bank;
          if (eff_col == COL_LAST) begin
            col_nxt   = '0;
            state_nxt = ST_WAIT;
          end else begin
            col_nxt = eff_col + LOG_N_COLS'(1);
          end
        end
      end

      ST_WAIT: begin
        if (wr_row_rdy) begin
          state_nxt = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        wr_row_store = 1'b1;
        wr_row_swap  = 1'b1;
        frame_done   = (bank == BANK_LAST) && (row == ROW_LAST);
        state_nxt    = ST_FILL;
        // Row address moves on only after the commit cycle has presented it.
        if (row == ROW_LAST) begin
          row_nxt  = '0;
          bank_nxt = (bank == BANK_LAST) ? '0 : bank + LOG_N_BANKS'(1);
        end else begin
          row_nxt = row + LOG_N_ROWS'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_hub75_stream_writer.sv
// Self-checking bench for hub75_stream_writer on a 2x4x8 geometry with a
// write-in model that holds wr_row_rdy low for 12 cycles after each store.
`timescale 1ns/1ps
module tb_hub75_stream_writer;

  localparam int NB = 2;
  localparam int NR = 4;
  localparam int NC = 8;
  localparam int DW = 24;
  localparam int FRAME = NB * NR * NC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:0]    wr_bank_addr;
  logic [1:0]    wr_row_addr;
  logic          wr_row_store;
  logic          wr_row_rdy;
  logic          wr_row_swap;
  logic [DW-1:0] wr_data;
  logic [2:0]    wr_col_addr;
  logic          wr_en;
  logic          frame_done;
  logic          sof_err;

  hub75_stream_writer #(
    .N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .N_CHANS(3), .N_PLANES(8)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .wr_bank_addr(wr_bank_addr),
    .wr_row_addr(wr_row_addr), .wr_row_store(wr_row_store),
    .wr_row_rdy(wr_row_rdy), .wr_row_swap(wr_row_swap), .wr_data(wr_data),
    .wr_col_addr(wr_col_addr), .wr_en(wr_en), .frame_done(frame_done),
    .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Write-in stage model: busy for 12 cycles after a store, plus a test hold.
  int   busy = 0;
  logic hold = 1'b0;
  logic st_seen = 1'b0;
  assign wr_row_rdy = (busy == 0) && !hold;

  always @(negedge clk) st_seen = wr_row_store;
  always @(posedge clk) begin
    #1;
    if (st_seen) busy = 12;
    else if (busy > 0) busy = busy - 1;
  end

  // Observed commit log.
  int log_br[$];
  int log_fd[$];
  int log_lat[$];
  int n_err = 0;
  int last_wr = 0;

  // Reference model: frame position as a flat pixel index.
  int   cyc = 0;
  int   p = 0;
  int   pp;
  bit   idle = 1'b1;
  bit   pending = 1'b0;
  int   pend = 0;
  int   last_acc = 0;
  bit   rdy_prev = 1'b0;
  bit   e_ready, e_wren, e_store, e_swap, e_fd, e_err;
  int   e_bank, e_row, e_col;
  logic [11:0]   got_v, exp_v;
  logic [DW-1:0] got_d, exp_d;

  always @(negedge clk) begin
    cyc = cyc + 1;
    {e_ready, e_wren, e_store, e_swap, e_fd, e_err} = '0;
    e_bank = 0; e_row = 0; e_col = 0;
    if (rst) begin
      idle = 1'b1; p = 0; pending = 1'b0;
    end else if (idle) begin
      idle = 1'b0;
    end else if (pending) begin
      e_bank = pend / NR; e_row = pend % NR;
      if (cyc >= last_acc + 2 && rdy_prev) begin
        e_store = 1'b1; e_swap = 1'b1; e_fd = (pend == NB * NR - 1);
        pending = 1'b0;
      end
    end else begin
      e_ready = 1'b1;
      pp = p;
      if (in_valid) begin
        e_wren = 1'b1;
        if (in_sof && p != 0) begin e_err = 1'b1; pp = 0; end
      end
      e_col = pp % NC; e_row = (pp / NC) % NR; e_bank = pp / (NC * NR);
      if (in_valid) begin
        p = (pp + 1) % FRAME;
        if (p % NC == 0) begin pending = 1'b1; pend = pp / NC; last_acc = cyc; end
      end
    end
    rdy_prev = wr_row_rdy;

    exp_v = {e_ready, e_wren, e_store, e_swap, e_fd, e_err,
             1'(e_bank), 2'(e_row), 3'(e_col)};
    got_v = {in_ready, wr_en, wr_row_store, wr_row_swap, frame_done, sof_err,
             wr_bank_addr, wr_row_addr, wr_col_addr};
    exp_d = e_wren ? in_data : '0;
    got_d = e_wren ? wr_data : '0;
    checks = checks + 1;
    if (got_v !== exp_v || got_d !== exp_d) begin
      errors = errors + 1;
      $display("FAIL cycle_%0d outputs{rdy,en,st,sw,fd,err,b,r,c} got=%b exp=%b data got=%h exp=%h",
               cyc, got_v, exp_v, got_d, exp_d);
    end

    if (wr_row_store) begin
      log_br.push_back(int'(wr_bank_addr) * NR + int'(wr_row_addr));
      log_fd.push_back(int'(frame_done));
      log_lat.push_back(cyc - last_wr);
    end
    if (wr_en) last_wr = cyc;
    if (sof_err) n_err = n_err + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_sof = s;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic stop_stream();
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_run(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) send(base + DW'(i), 1'b0);
    stop_stream();
  endtask

  task automatic wait_commits(input int target);
    for (int i = 0; i < 400 && log_br.size() < target; i++) begin
      @(posedge clk);
      #1;
    end
    if (log_br.size() < target) chk("commit_timeout", log_br.size(), target);
  endtask

  task automatic do_reset();
    stop_stream();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int base;
  int fd_cnt;

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: single row after reset.
    do_reset();
    chk("t1_ready_idle", int'(in_ready), 0);
    send_run(NC, 24'h000000);
    wait_commits(1);
    chk("t1_commit_row", log_br[0], 0);
    chk("t1_commit_latency", log_lat[0], 2);

    // T2: full frame with start-of-frame on the first pixel.
    do_reset();
    base = log_br.size();
    send(24'h100000, 1'b1);
    send_run(FRAME - 1, 24'h100001);
    wait_commits(base + NB * NR);
    for (int k = 0; k < NB * NR; k++) begin
      chk("t2_row_seq", log_br[base + k], k);
      chk("t2_frame_done", log_fd[base + k], (k == NB * NR - 1) ? 1 : 0);
    end
    chk("t2_no_sof_err", n_err, 0);

    // T3: write-in holds rdy low for 40 cycles after row 1 fills.
    base = log_br.size();
    send_run(NC, 24'h200000);
    wait_commits(base + 1);
    hold = 1'b1;
    send_run(NC, 24'h200100);
    repeat (40) begin @(posedge clk); #1; end
    chk("t3_no_commit_on_hold", log_br.size(), base + 1);
    hold = 1'b0;
    wait_commits(base + 2);
    chk("t3_commit_row", log_br[base + 1], 1);

    // T4: start-of-frame arriving at column 5 of row (0,2).
    base = log_br.size();
    for (int i = 0; i < 5; i++) send(24'h300000 + DW'(i), 1'b0);
    send(24'h3000AA, 1'b1);
    send_run(NC - 1, 24'h300010);
    wait_commits(base + 1);
    chk("t4_sof_err_count", n_err, 1);
    chk("t4_resync_row", log_br[base], 0);

    // T5: reset at column 3 of row (1,1).
    base = log_br.size();
    send_run(4 * NC + 3, 24'h400000);
    chk("t5_commits_before_rst", log_br.size(), base + 4);
    chk("t5_last_row_before_rst", log_br[base + 3], NR);
    do_reset();
    base = log_br.size();
    send_run(NC, 24'h410000);
    wait_commits(base + 1);
    chk("t5_row_after_rst", log_br[base], 0);

    // T6: finish the frame, then a second frame with no start-of-frame.
    base = log_br.size();
    send_run(FRAME - NC, 24'h500000);
    wait_commits(base + NB * NR - 1);
    chk("t6_end_of_frame1", log_fd[base + NB * NR - 2], 1);
    base = log_br.size();
    send_run(FRAME, 24'h600000);
    wait_commits(base + NB * NR);
    chk("t6_wrap_row", log_br[base], 0);
    fd_cnt = 0;
    for (int k = 0; k < NB * NR; k++) fd_cnt = fd_cnt + log_fd[base + k];
    chk("t6_frame_done_count", fd_cnt, 1);
    chk("t6_frame_done_last", log_fd[base + NB * NR - 1], 1);

    repeat (4) begin @(posedge clk); #1; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
